// File: rtl/lpm_or_seq_pkg.sv
// Shared types for lpm_or_seq: FSM state encoding and the beat-counter width helper.
package lpm_or_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int size);
        return (size <= 1) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/lpm_or_seq_acc.sv
// lpm_or_seq_acc: word-wide OR accumulator with clear/load/or-in controls and async active-low clear.
module lpm_or_seq_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             or_in_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // clear wins over load, load wins over or-in
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = data_i;
        end else if (or_in_i) begin
            acc_d = acc_q | data_i;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/lpm_or_seq.sv
// lpm_or_seq: serial OR-reduction of lpm_size words over valid/ready in and out.
// Define LPM_OR_SEQ_SKID_EN for a separate output register that lets the next group accumulate.
module lpm_or_seq
    import lpm_or_seq_pkg::*;
#(
    parameter     lpm_type  = "lpm_or_seq",
    parameter int lpm_width = 8,
    parameter int lpm_size  = 4,
    parameter     lpm_hint  = "UNUSED"
) (
    input  logic                         clock,
    input  logic                         aclr_n,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic [lpm_width-1:0]         data,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [lpm_width-1:0]         result,
    output logic                         busy,
    output logic [cnt_w(lpm_size)-1:0]   beat_count,
    output logic [1:0]                   state_o
);

    localparam int               CNT_W = cnt_w(lpm_size);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(lpm_size - 1);

    if (lpm_width < 1 || lpm_size < 1 || $bits(lpm_type) < 8 || $bits(lpm_hint) < 8) begin : g_param_check
        $error("lpm_or_seq: lpm_width and lpm_size must be >= 1, type/hint non-empty");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on the same-cycle valid of either port.
    state_t           state_q;
    logic [CNT_W-1:0] beat_q;
    logic             valid_q;
    logic [lpm_width-1:0] acc;
    logic             in_xfer;
    logic             last_xfer;
    logic             acc_clear;

    assign in_xfer   = data_valid && data_ready;
    assign last_xfer = in_xfer && (beat_q == LAST);

    lpm_or_seq_acc #(
        .WIDTH (lpm_width)
    ) u_acc (
        .clock   (clock),
        .aclr_n  (aclr_n),
        .clear_i (acc_clear),
        .load_i  (in_xfer && (state_q == ST_IDLE)),
        .or_in_i (in_xfer && (state_q == ST_ACC)),
        .data_i  (data),
        .acc_o   (acc)
    );

`ifdef LPM_OR_SEQ_SKID_EN
    logic [lpm_width-1:0] out_q;
    logic [lpm_width-1:0] acc_next;

    assign acc_next   = (state_q == ST_IDLE) ? data : (acc | data);
    // Only the closing beat must wait for the output register to be free.
    assign data_ready = !(valid_q && (beat_q == LAST));
    assign acc_clear  = last_xfer;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (last_xfer) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b1;
            out_q   <= acc_next;
        end else begin
            if (result_ready) begin
                valid_q <= 1'b0;
            end
            if (in_xfer) begin
                state_q <= ST_ACC;
                beat_q  <= beat_q + 1'b1;
            end
        end
    end

    assign result = out_q;
`else
    assign data_ready = (state_q != ST_DONE);
    assign acc_clear  = 1'b0;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (in_xfer) begin
                        if (beat_q == LAST) begin
                            state_q <= ST_DONE;
                            beat_q  <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACC;
                            beat_q  <= beat_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result = acc;
`endif

    assign result_valid = valid_q;
    assign busy         = (state_q == ST_ACC);
    assign beat_count   = beat_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_lpm_or_seq.sv
// Directed bench for lpm_or_seq: group reduction, stalls, single-word groups, reset, skid mode.
module tb_lpm_or_seq;

    localparam int W = 8;
`ifdef LPM_OR_SEQ_SKID_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 5;
`endif

    // clock / reset
    logic clock = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // lpm_size = 4 instance
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic [W-1:0] data = '0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;
    logic [1:0]   beat_count;
    logic [1:0]   state_o;

    lpm_or_seq #(.lpm_width(W), .lpm_size(4)) u_dut (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data         (data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy),
        .beat_count   (beat_count),
        .state_o      (state_o)
    );

    // lpm_size = 1 instance
    logic         v1_valid = 1'b0;
    logic         v1_ready;
    logic [W-1:0] v1_data = '0;
    logic         r1_valid;
    logic         r1_ready = 1'b0;
    logic [W-1:0] r1;
    logic         busy1;
    logic [0:0]   beat1;
    logic [1:0]   state1;
    logic         busy1_seen = 1'b0;

    lpm_or_seq #(.lpm_width(W), .lpm_size(1)) u_dut1 (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .data_valid   (v1_valid),
        .data_ready   (v1_ready),
        .data         (v1_data),
        .result_valid (r1_valid),
        .result_ready (r1_ready),
        .result       (r1),
        .busy         (busy1),
        .beat_count   (beat1),
        .state_o      (state1)
    );

    always @(negedge clock) if (busy1) busy1_seen = 1'b1;

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : out_monitor
        logic [W-1:0] exp_v;
        if (aclr_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("result_unexpected", 32'(result), 32'h1ff);
            end else begin
                exp_v = exp_q.pop_front();
                check("result_out", 32'(result), 32'(exp_v));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        logic rdy;
        data       = w;
        data_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rdy = data_ready;
            tick();
            if (rdy) return;
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) tick();
    endtask

    logic [W-1:0] grp [3][4] = '{'{8'h01, 8'h02, 8'h10, 8'h80},
                                 '{8'h0F, 8'hF0, 8'h00, 8'h00},
                                 '{8'h20, 8'h20, 8'h04, 8'h00}};
    logic [W-1:0] grp_exp [3] = '{8'h93, 8'hFF, 8'h24};

    initial begin
        int prev_cyc;
        prev_cyc = 0;

        // reset values while aclr_n is low
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beat", 32'(beat_count), 32'd0);
        aclr_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(data_ready), 32'd1);

        // back-to-back groups, sink always ready
        result_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int w = 0; w < 4; w++) begin
                send(grp[g][w]);
                if (w < 3) begin
                    check("t1_beat", 32'(beat_count), 32'(w + 1));
                    check("t1_valid_low", 32'(result_valid), 32'd0);
                end
            end
            exp_q.push_back(grp_exp[g]);
            check("t1_valid", 32'(result_valid), 32'd1);
            check("t1_result", 32'(result), 32'(grp_exp[g]));
            check("t1_beat_wrap", 32'(beat_count), 32'd0);
            check("t1_busy", 32'(busy), 32'd0);
            if (g > 0) check("t1_period", 32'(cyc - prev_cyc), 32'(PERIOD));
            prev_cyc = cyc;
        end
        idle(2);

`ifndef LPM_OR_SEQ_SKID_EN
        // gaps between beats, sink stalls in DONE
        result_ready = 1'b0;
        send(8'h01); idle(3);
        send(8'h02); idle(3);
        send(8'h10); idle(3);
        send(8'h80);
        exp_q.push_back(8'h93);
        check("t2_valid", 32'(result_valid), 32'd1);
        data       = 8'h40;
        data_valid = 1'b1;
        repeat (5) begin
            tick();
            check("t2_hold_result", 32'(result), 32'h93);
            check("t2_hold_ready", 32'(data_ready), 32'd0);
            check("t2_hold_valid", 32'(result_valid), 32'd1);
        end
        result_ready = 1'b1;
        tick();
        check("t2_taken_valid", 32'(result_valid), 32'd0);
        check("t2_not_accepted", 32'(beat_count), 32'd0);
        check("t2_idle_ready", 32'(data_ready), 32'd1);
        send(8'h40);
        check("t2_next_beat", 32'(beat_count), 32'd1);
        check("t2_next_busy", 32'(busy), 32'd1);
        send(8'h04); send(8'h00); send(8'h00);
        exp_q.push_back(8'h44);
        check("t2_result2", 32'(result), 32'h44);
        idle(2);
`else
        // skid: next group accumulates while the previous result waits
        result_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h04); send(8'h08);
        exp_q.push_back(8'h0F);
        check("sk_valid", 32'(result_valid), 32'd1);
        check("sk_ready_open", 32'(data_ready), 32'd1);
        send(8'h10); send(8'h20); send(8'h40);
        check("sk_beat3", 32'(beat_count), 32'd3);
        check("sk_ready_stall", 32'(data_ready), 32'd0);
        check("sk_held", 32'(result), 32'h0F);
        data       = 8'h80;
        data_valid = 1'b1;
        repeat (2) begin
            tick();
            check("sk_stall_ready", 32'(data_ready), 32'd0);
            check("sk_stall_beat", 32'(beat_count), 32'd3);
        end
        result_ready = 1'b1;
        tick();
        check("sk_taken_valid", 32'(result_valid), 32'd0);
        check("sk_release_ready", 32'(data_ready), 32'd1);
        tick();
        exp_q.push_back(8'hF0);
        check("sk_result2", 32'(result), 32'hF0);
        check("sk_valid2", 32'(result_valid), 32'd1);
        idle(2);
`endif

        // lpm_size = 1
        r1_ready = 1'b1;
        v1_data  = 8'hA5;
        v1_valid = 1'b1;
        tick();
        check("s1_valid_a", 32'(r1_valid), 32'd1);
        check("s1_result_a", 32'(r1), 32'hA5);
        check("s1_ready_a", 32'(v1_ready), 32'd0);
        check("s1_beat", 32'(beat1), 32'd0);
        v1_data = 8'h5A;
        tick();
        check("s1_taken", 32'(r1_valid), 32'd0);
        tick();
        check("s1_valid_b", 32'(r1_valid), 32'd1);
        check("s1_result_b", 32'(r1), 32'h5A);
        v1_valid = 1'b0;
        tick();
        check("s1_drained", 32'(r1_valid), 32'd0);
        check("s1_busy_never", 32'(busy1_seen), 32'd0);

        // reset mid-group discards the partial OR
        result_ready = 1'b1;
        send(8'hFF); send(8'h00);
        check("t4_beat2", 32'(beat_count), 32'd2);
        data_valid = 1'b0;
        #2;
        aclr_n = 1'b0;
        #1;
        check("t4_rst_valid", 32'(result_valid), 32'd0);
        check("t4_rst_result", 32'(result), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_beat", 32'(beat_count), 32'd0);
        @(posedge clock);
        #1;
        aclr_n = 1'b1;
        tick();
        check("t4_ready", 32'(data_ready), 32'd1);
        send(8'h01); send(8'h02); send(8'h04); send(8'h08);
        exp_q.push_back(8'h0F);
        check("t4_result", 32'(result), 32'h0F);
        idle(3);

        // final report
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
